// File: rtl/stream_busmerge_if.sv
// stream_busmerge_if: two input streams plus one merged output stream with valid/ready handshakes
interface stream_busmerge_if #(parameter int WA = 48, parameter int WB = 64);
  logic          a_valid, a_ready, b_valid, b_ready, q_valid, q_ready;
  logic [WA-1:0] a_data;
  logic [WB-1:0] b_data;
  logic [WA+WB-1:0] q_data;
  modport slave (input a_valid, a_data, b_valid, b_data, q_ready, output a_ready, b_ready, q_valid, q_data);
  modport master (output a_valid, a_data, b_valid, b_data, q_ready, input a_ready, b_ready, q_valid, q_data);
endinterface

// File: rtl/stream_busmerge.sv
// stream_busmerge: pairs A and B words in arrival order into one output word; BUSMERGE_CNT_EN adds merge_cnt
module stream_busmerge #(
  parameter int WA = 48,
  parameter int WB = 64,
  parameter int ORDER = 0
) (
  input  logic clk,
  input  logic rst_n,
  stream_busmerge_if.slave bus
`ifdef BUSMERGE_CNT_EN
  ,
  output logic [15:0] merge_cnt
`endif
);
  logic [WA-1:0]    a_hold_q, a_hold_d;
  logic [WB-1:0]    b_hold_q, b_hold_d;
  logic [WA+WB-1:0] q_data_q, q_data_d;
  logic             a_hold_v_q, a_hold_v_d, b_hold_v_q, b_hold_v_d, q_valid_q, q_valid_d;
  logic             merge, a_acc, b_acc;
  always_comb begin
    merge       = rst_n & a_hold_v_q & b_hold_v_q & (~q_valid_q | bus.q_ready);
    bus.a_ready = rst_n & (~a_hold_v_q | merge);
    bus.b_ready = rst_n & (~b_hold_v_q | merge);
    a_acc       = bus.a_valid & bus.a_ready;
    b_acc       = bus.b_valid & bus.b_ready;
    a_hold_d    = a_acc ? bus.a_data : a_hold_q;
    b_hold_d    = b_acc ? bus.b_data : b_hold_q;
    a_hold_v_d  = a_acc | (a_hold_v_q & ~merge);
    b_hold_v_d  = b_acc | (b_hold_v_q & ~merge);
    q_data_d    = merge ? (ORDER != 0 ? {b_hold_q, a_hold_q} : {a_hold_q, b_hold_q}) : q_data_q;
    q_valid_d   = merge | (q_valid_q & ~bus.q_ready);
    bus.q_valid = q_valid_q;
    bus.q_data  = q_data_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_hold_q   <= '0;
      b_hold_q   <= '0;
      q_data_q   <= '0;
      a_hold_v_q <= 1'b0;
      b_hold_v_q <= 1'b0;
      q_valid_q  <= 1'b0;
    end else begin
      a_hold_q   <= a_hold_d;
      b_hold_q   <= b_hold_d;
      q_data_q   <= q_data_d;
      a_hold_v_q <= a_hold_v_d;
      b_hold_v_q <= b_hold_v_d;
      q_valid_q  <= q_valid_d;
    end
  end
`ifdef BUSMERGE_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  always_comb cnt_d = (q_valid_q & bus.q_ready & ~&cnt_q) ? cnt_q + 16'd1 : cnt_q;
  always_ff @(posedge clk) cnt_q <= rst_n ? cnt_d : 16'd0;
  assign merge_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_stream_busmerge.sv
// tb_stream_busmerge: random and directed stimulus on ORDER=0 and ORDER=1 instances against an in-order pairing scoreboard
module tb_stream_busmerge;
  localparam int WA = 48, WB = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  stream_busmerge_if #(.WA(WA), .WB(WB)) i0 ();
  stream_busmerge_if #(.WA(WA), .WB(WB)) i1 ();
  assign i1.a_valid = i0.a_valid;
  assign i1.a_data  = i0.a_data;
  assign i1.b_valid = i0.b_valid;
  assign i1.b_data  = i0.b_data;
  assign i1.q_ready = i0.q_ready;
`ifdef BUSMERGE_CNT_EN
  logic [15:0] cnt0, cnt1;
`endif
  stream_busmerge #(.WA(WA), .WB(WB), .ORDER(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(i0)
`ifdef BUSMERGE_CNT_EN
    , .merge_cnt(cnt0)
`endif
  );
  stream_busmerge #(.WA(WA), .WB(WB), .ORDER(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1)
`ifdef BUSMERGE_CNT_EN
    , .merge_cnt(cnt1)
`endif
  );
  int n_tests = 0, n_fail = 0, n_cons = 0;
  logic [WA-1:0]    qa[$];
  logic [WB-1:0]    qb[$];
  logic [WA+WB-1:0] e0[$], e1[$];
  logic [WA+WB-1:0] last;
  logic             stall = 1'b0;
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic fail(input string name, input int act, input int exp);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("ready_in_reset", {i0.a_ready, i0.b_ready, i1.a_ready, i1.b_ready}, 4'b0000);
      qa.delete();
      qb.delete();
      e0.delete();
      e1.delete();
      stall = 1'b0;
    end else begin
      if (qa.size() != 0) chk("a_waits_not_ready", i0.a_ready, 1'b0);
      if (qb.size() != 0) chk("b_waits_not_ready", i0.b_ready, 1'b0);
      if (qa.size() == 0 && qb.size() == 0 && e0.size() == 0)
        chk("idle_state", {i0.a_ready, i0.b_ready, i0.q_valid}, 3'b110);
      if (stall) chk("stall_stable", {i0.q_valid, i0.q_data}, {1'b1, last});
      if (i0.q_valid && i0.q_ready) begin
        n_cons++;
        if (e0.size() == 0) fail("unexpected_out0", 1, 0);
        else chk("q_data_order0", i0.q_data, e0.pop_front());
      end
      if (i1.q_valid && i1.q_ready) begin
        if (e1.size() == 0) fail("unexpected_out1", 1, 0);
        else chk("q_data_order1", i1.q_data, e1.pop_front());
      end
      stall = i0.q_valid & ~i0.q_ready;
      last  = i0.q_data;
      if (i0.a_valid && i0.a_ready) qa.push_back(i0.a_data);
      if (i0.b_valid && i0.b_ready) qb.push_back(i0.b_data);
      while (qa.size() != 0 && qb.size() != 0) begin
        logic [WA-1:0] a;
        logic [WB-1:0] b;
        a = qa.pop_front();
        b = qb.pop_front();
        e0.push_back({a, b});
        e1.push_back({b, a});
      end
    end
  end
  task automatic drain(input int lim);
    int k = 0;
    i0.a_valid = 1'b0;
    i0.b_valid = 1'b0;
    i0.q_ready = 1'b1;
    while ((e0.size() != 0 || e1.size() != 0) && k < lim) begin
      @(negedge clk);
      step();
      k++;
    end
    if (e0.size() != 0 || e1.size() != 0) fail("drain_timeout", e0.size(), 0);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c0, ia, ib;
    logic saw;
    i0.a_valid = 1'b0;
    i0.b_valid = 1'b0;
    i0.q_ready = 1'b0;
    i0.a_data  = '0;
    i0.b_data  = '0;
    step();
    do_reset();
    @(negedge clk);
    chk("reset_state", {i0.q_valid, i0.a_ready, i0.b_ready}, 3'b011);
    chk("reset_qdata", i0.q_data, 0);
    step();
    // both words in the same cycle: visible two edges later, for one cycle
    i0.a_valid = 1'b1; i0.a_data = 48'h0000_1111_2222;
    i0.b_valid = 1'b1; i0.b_data = 64'hAAAA_BBBB_CCCC_DDDD;
    i0.q_ready = 1'b1;
    @(negedge clk);
    chk("accept_ready", {i0.a_ready, i0.b_ready}, 2'b11);
    step();
    i0.a_valid = 1'b0; i0.b_valid = 1'b0;
    @(negedge clk);
    chk("latency_e", i0.q_valid, 1'b0);
    step();
    @(negedge clk);
    chk("latency_e1_valid", i0.q_valid, 1'b1);
    chk("order0_literal", i0.q_data, 112'h0000_1111_2222_AAAA_BBBB_CCCC_DDDD);
    chk("order1_literal", i1.q_data, 112'hAAAA_BBBB_CCCC_DDDD_0000_1111_2222);
    step();
    @(negedge clk);
    chk("held_one_cycle", i0.q_valid, 1'b0);
    step();
    // A arrives three cycles before its partner
    i0.a_valid = 1'b1; i0.a_data = 48'h1234_5678_9ABC;
    @(negedge clk);
    step();
    i0.a_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("a_wait", {i0.a_ready, i0.q_valid}, 2'b00);
      step();
    end
    i0.b_valid = 1'b1; i0.b_data = 64'h0F0F_0F0F_F0F0_F0F0;
    @(negedge clk);
    step();
    i0.b_valid = 1'b0;
    @(negedge clk);
    chk("late_b_merge_cycle", i0.q_valid, 1'b0);
    step();
    @(negedge clk);
    chk("late_b_pair", i0.q_data, 112'h1234_5678_9ABC_0F0F_0F0F_F0F0_F0F0);
    step();
    // 10 pairs with downstream stalled for the first 5 cycles
    ia = 0; ib = 0; saw = 1'b0; c0 = n_cons;
    for (int cyc = 0; cyc < 80 && (ia < 10 || ib < 10); cyc++) begin
      i0.q_ready = (cyc >= 5);
      i0.a_valid = (ia < 10); i0.a_data = WA'(ia + 48'h100);
      i0.b_valid = (ib < 10); i0.b_data = WB'(ib + 64'h200);
      @(negedge clk);
      if (!i0.a_ready && !i0.b_ready && i0.q_valid) saw = 1'b1;
      if (i0.a_valid && i0.a_ready) ia++;
      if (i0.b_valid && i0.b_ready) ib++;
      step();
    end
    drain(40);
    chk("backpressure_seen", saw, 1'b1);
    chk("ten_pairs_out", n_cons - c0, 10);
    // throughput: one merged word per cycle at steady state
    i0.a_valid = 1'b1; i0.b_valid = 1'b1; i0.q_ready = 1'b1;
    c0 = n_cons;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc == 10) c0 = n_cons;
      i0.a_data = {$urandom, $urandom};
      i0.b_data = {$urandom, $urandom};
      @(negedge clk);
      step();
    end
    chk("throughput", n_cons - c0, 20);
    drain(20);
    // reset while both holds and output are full
    saw = 1'b0;
    i0.a_valid = 1'b1; i0.b_valid = 1'b1; i0.q_ready = 1'b0;
    for (int cyc = 0; cyc < 10 && !saw; cyc++) begin
      i0.a_data = {$urandom, $urandom};
      i0.b_data = {$urandom, $urandom};
      @(negedge clk);
      saw = i0.q_valid & ~i0.a_ready & ~i0.b_ready;
      step();
    end
    chk("full_before_reset", saw, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    step();
    rst_n = 1'b1;
    i0.a_valid = 1'b0; i0.b_valid = 1'b0; i0.q_ready = 1'b1;
    @(negedge clk);
    chk("after_mid_reset", {i0.q_valid, i0.a_ready, i0.b_ready}, 3'b011);
    step();
    c0 = n_cons;
    repeat (5) begin
      @(negedge clk);
      step();
    end
    chk("old_words_gone", n_cons - c0, 0);
    // random traffic with occasional resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n      = ($urandom_range(399) != 0);
      i0.a_valid = ($urandom_range(2) != 0);
      i0.b_valid = ($urandom_range(2) != 0);
      i0.q_ready = ($urandom_range(3) != 0);
      i0.a_data  = {$urandom, $urandom};
      i0.b_data  = {$urandom, $urandom};
      @(negedge clk);
      step();
    end
    rst_n = 1'b1;
    drain(20);
`ifdef BUSMERGE_CNT_EN
    do_reset();
    chk("cnt_reset", {cnt0, cnt1}, 32'h0);
    c0 = n_cons;
    i0.a_valid = 1'b1; i0.b_valid = 1'b1; i0.q_ready = 1'b1;
    for (int cyc = 0; cyc < 70100 && n_cons - c0 < 70000; cyc++) begin
      i0.a_data = {$urandom, $urandom};
      i0.b_data = {$urandom, $urandom};
      @(negedge clk);
      step();
      if (cyc % 4096 == 100)
        chk("cnt_track", cnt0, (n_cons - c0 > 65535) ? 16'hFFFF : 16'(n_cons - c0));
    end
    drain(20);
    chk("cnt_consumes", n_cons - c0 >= 70000, 1'b1);
    chk("cnt_saturated", {cnt0, cnt1}, 32'hFFFF_FFFF);
    do_reset();
    chk("cnt_cleared", {cnt0, cnt1}, 32'h0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_busmerge.md
STREAM_BUSMERGE -- requirements
Module: stream_busmerge

Interface
REQ-001 The block SHALL expose parameter WA, default 48: width of stream A data.
REQ-002 The block SHALL expose parameter WB, default 64: width of stream B data.
REQ-003 The block SHALL expose parameter ORDER, default 0: 0 gives q_data = {A,B}; 1 gives q_data = {B,A}.
REQ-004 The block SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-006 The block SHALL have port a_valid, input, 1: stream A word offered.
REQ-007 The block SHALL have port a_data, input, WA: stream A word.
REQ-008 The block SHALL have port a_ready, output, 1: stream A word accepted this cycle when a_valid&a_ready.
REQ-009 The block SHALL have ports b_valid (input, 1), b_data (input, WB) and b_ready (output, 1), with the same meanings for stream B.
REQ-010 The block SHALL have port q_valid, output, 1: merged word present.
REQ-011 The block SHALL have port q_data, output, WA+WB: merged word.
REQ-012 The block SHALL have port q_ready, input, 1: downstream consumes q_data when q_valid&q_ready.

Function
REQ-013 The block SHALL hold one-entry registers per input: a_hold/a_hold_v and b_hold/b_hold_v.
REQ-014 The block SHALL define merge = a_hold_v & b_hold_v & (~q_valid | q_ready).
REQ-015 The block SHALL drive a_ready = ~a_hold_v | merge, and b_ready = ~b_hold_v | merge, combinationally.
REQ-016 On a stream A accept, the block SHALL load a_hold and set a_hold_v; otherwise, on merge, it SHALL clear a_hold_v. Stream B SHALL behave likewise.
REQ-017 On merge, the block SHALL load q_data with the ORDER-selected concatenation of a_hold and b_hold and set q_valid.
REQ-018 Without merge, on a q consume the block SHALL clear q_valid.
REQ-019 q_data SHALL remain stable while q_valid=1 and q_ready=0.
REQ-020 Latency SHALL be 2 cycles: both words accepted at edge E give q_valid=1 after edge E+1.
REQ-021 With A and B valid every cycle and q_ready=1, throughput SHALL be one merged word per cycle.
REQ-022 A and B SHALL be accepted independently; a word waits in its hold register for its partner without limit, and pairing SHALL be strictly in arrival order.
REQ-023 When merge and a new accept on the same side occur in the same cycle, the hold register SHALL take the new word and a_hold_v (or b_hold_v) SHALL stay 1.
REQ-024 Merge and consume in the same cycle SHALL keep q_valid=1 with the new data.
REQ-025 No word SHALL be dropped or duplicated under any valid/ready combination.

Reset
REQ-026 When rst_n=0 at a clk edge, a_hold_v, b_hold_v and q_valid SHALL become 0; a_hold, b_hold and q_data SHALL become 0.
REQ-027 Reset mid-operation SHALL discard all held and output words; a_ready and b_ready SHALL read 1 in the cycle after reset.
REQ-028 While rst_n=0, a_ready and b_ready SHALL be 0, and accepts and merges SHALL be suppressed.

Configuration
REQ-029 With macro BUSMERGE_CNT_EN defined, the block SHALL add output merge_cnt [15:0]: incremented on each q consume, saturating at 16'hFFFF, cleared to 0 by reset.
REQ-030 Without BUSMERGE_CNT_EN, the port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-031 Reset, then A=48'h0000_1111_2222 and B=64'hAAAA_BBBB_CCCC_DDDD in the same cycle, q_ready=1 -> two cycles later q_valid=1, q_data=112'h0000_1111_2222_AAAA_BBBB_CCCC_DDDD, held one cycle.
REQ-032 ORDER=1, same stimulus -> q_data=112'hAAAA_BBBB_CCCC_DDDD_0000_1111_2222.
REQ-033 A sent 3 cycles before B -> a_ready=0 while A waits; merge occurs only after B arrives; data pairs correctly.
REQ-034 q_ready=0 for 5 cycles with streams continuous -> q_data stable; a_ready and b_ready drop once holds fill; no loss after q_ready=1; 10 pairs out in order.
REQ-035 rst_n=0 for one cycle with q_valid=1 and both holds full -> q_valid=0, a_ready=b_ready=1 next cycle; the old words never appear.
REQ-036 With BUSMERGE_CNT_EN, 70000 consumes -> merge_cnt=16'hFFFF; reset -> 0.
